// File: rtl/embertrail_fetch_pkg.sv
// Shared definitions for the Embertrail fetch responder: widths, FSM encoding, the dual-issue
// bit and the reset fetch address agreed with the control unit.
package embertrail_fetch_pkg;

  localparam int unsigned HwWidth   = 16;
  localparam int unsigned WordWidth = 32;
  localparam int unsigned DualBit   = 15;

  localparam logic [HwWidth-1:0] ResetPcDefault = 16'h0000;

  typedef enum logic [1:0] {
    FetchIdle  = 2'd0,
    FetchReq   = 2'd1,
    FetchDrain = 2'd2
  } fetch_state_e;

  // Halfwords occupied by the packet starting with this instruction.
  function automatic logic [1:0] pkt_len(input logic [HwWidth-1:0] hw);
    return hw[DualBit] ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/embertrail_fetch_if.sv
// Fetch bus: instruction-memory request channel plus the packet channel to the control unit.
// master = fetch responder side, slave = memory / control unit side.
interface embertrail_fetch_if;
  import embertrail_fetch_pkg::*;

  logic                 mem_req;
  logic [14:0]          mem_addr;
  logic                 mem_ack;
  logic [WordWidth-1:0] mem_rdata;
  logic [WordWidth-1:0] ir;
  logic [HwWidth-1:0]   pc;
  logic                 ir_valid;
  logic                 take;
  logic                 redirect;
  logic [HwWidth-1:0]   redirect_pc;

  modport master (
    output mem_req, mem_addr, ir, pc, ir_valid,
    input  mem_ack, mem_rdata, take, redirect, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, ir, pc, ir_valid,
    output mem_ack, mem_rdata, take, redirect, redirect_pc
  );

endinterface

// File: rtl/embertrail_hw_fifo.sv
// Circular halfword buffer: pushes and pops of one or two halfwords per cycle, plus flush.
// Caller guarantees no overflow/underflow; head and next are the two oldest entries.
module embertrail_hw_fifo
  import embertrail_fetch_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned Aw   = $clog2(Depth)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [1:0]           push_cnt,
  input  logic [WordWidth-1:0] push_data,
  input  logic [1:0]           pop_cnt,
  output logic [Aw:0]          count,
  output logic [HwWidth-1:0]   head,
  output logic [HwWidth-1:0]   next
);

  logic [HwWidth-1:0] mem_q [Depth];
  logic [Aw-1:0]      rd_q;
  logic [Aw:0]        count_q;
  logic [Aw-1:0]      wr0, wr1, rd1;

  assign wr0   = rd_q + count_q[Aw-1:0];
  assign wr1   = wr0 + Aw'(1);
  assign rd1   = rd_q + Aw'(1);
  assign count = count_q;
  assign head  = mem_q[rd_q];
  assign next  = mem_q[rd1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_q + Aw'(pop_cnt);
      count_q <= count_q + (Aw+1)'(push_cnt) - (Aw+1)'(pop_cnt);
    end
  end

  // Storage needs no reset: entries are only observed when count covers them.
  always_ff @(posedge clk) begin
    if (!flush && push_cnt != 2'd0) begin
      mem_q[wr0] <= push_data[HwWidth-1:0];
    end
    if (!flush && push_cnt == 2'd2) begin
      mem_q[wr1] <= push_data[WordWidth-1:HwWidth];
    end
  end

endmodule

// File: rtl/embertrail_fetch.sv
// Instruction-fetch responder: fetches words, buffers halfwords, presents aligned 1/2-halfword
// packets. Define EMBERTRAIL_FETCH_PERF_EN to add the stall_cnt performance counter.
module embertrail_fetch
  import embertrail_fetch_pkg::*;
#(
  parameter int unsigned        BufDepth = 4,
  parameter logic [HwWidth-1:0] ResetPc  = ResetPcDefault
) (
  input  logic               clk,
  input  logic               rst_n,
  embertrail_fetch_if.master bus
`ifdef EMBERTRAIL_FETCH_PERF_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  localparam int unsigned Aw = $clog2(BufDepth);

  fetch_state_e         state_q;
  logic                 mem_req_q;
  logic [14:0]          mem_addr_q;
  logic [HwWidth-1:0]   fetch_ptr_q;
  logic [HwWidth-1:0]   pc_q;

  logic [Aw:0]          count;
  logic [HwWidth-1:0]   head, next;
  logic [1:0]           push_cnt, pop_cnt;
  logic [WordWidth-1:0] push_data;
  logic                 ir_valid;
  logic [WordWidth-1:0] ir;
  logic                 room;
  logic [HwWidth-1:0]   tgt_ptr;

  embertrail_hw_fifo #(
    .Depth (BufDepth)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.redirect),
    .push_cnt  (push_cnt),
    .push_data (push_data),
    .pop_cnt   (pop_cnt),
    .count     (count),
    .head      (head),
    .next      (next)
  );

  always_comb begin
    ir_valid = ((count != '0) && !head[DualBit]) || (count >= (Aw+1)'(2));
    ir       = '0;
    if (ir_valid) begin
      ir = head[DualBit] ? {next, head} : {16'h0000, head};
    end
  end

  // A new request always needs space for a full word.
  assign room    = count <= (Aw+1)'(BufDepth - 2);
  assign tgt_ptr = bus.redirect ? bus.redirect_pc : fetch_ptr_q;

  always_comb begin
    push_cnt  = 2'd0;
    push_data = bus.mem_rdata;
    if (state_q == FetchReq && bus.mem_ack && !bus.redirect) begin
      if (fetch_ptr_q[0]) begin
        // Odd target: the even halfword precedes the target and is dropped.
        push_cnt  = 2'd1;
        push_data = {16'h0000, bus.mem_rdata[WordWidth-1:HwWidth]};
      end else begin
        push_cnt  = 2'd2;
      end
    end
    pop_cnt = (bus.take && ir_valid && !bus.redirect) ? pkt_len(head) : 2'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FetchIdle;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      fetch_ptr_q <= ResetPc;
      pc_q        <= ResetPc;
    end else begin
      pc_q <= bus.redirect ? bus.redirect_pc : pc_q + HwWidth'(pop_cnt);
      case (state_q)
        FetchIdle: begin
          fetch_ptr_q <= tgt_ptr;
          if (bus.redirect || room) begin
            state_q    <= FetchReq;
            mem_req_q  <= 1'b1;
            mem_addr_q <= tgt_ptr[HwWidth-1:1];
          end
        end
        FetchReq: begin
          if (bus.redirect) begin
            fetch_ptr_q <= bus.redirect_pc;
            if (bus.mem_ack) begin
              mem_addr_q <= bus.redirect_pc[HwWidth-1:1];
            end else begin
              state_q <= FetchDrain;
            end
          end else if (bus.mem_ack) begin
            fetch_ptr_q <= fetch_ptr_q + (fetch_ptr_q[0] ? 16'd1 : 16'd2);
            state_q     <= FetchIdle;
            mem_req_q   <= 1'b0;
          end
        end
        FetchDrain: begin
          fetch_ptr_q <= tgt_ptr;
          if (bus.mem_ack) begin
            if (bus.redirect) begin
              state_q    <= FetchReq;
              mem_addr_q <= bus.redirect_pc[HwWidth-1:1];
            end else begin
              state_q   <= FetchIdle;
              mem_req_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= FetchIdle;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.ir       = ir;
  assign bus.pc       = pc_q;
  assign bus.ir_valid = ir_valid;

`ifdef EMBERTRAIL_FETCH_PERF_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (!ir_valid && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule
